conversor_bcd: RTL and testbench

Sequential signed-binary to BCD converter that drives the four-digit seven-segment display stage directly. It takes a 32-bit two's-complement value, such as the processor's output/IO register, and converts its magnitude with an iterative shift-add-3 (double-dabble) algorithm over 14 cycles. It then presents the sign bit plus four 4-bit digit codes (thousands, hundreds, tens, units), ready to be wired unchanged into the display decoder's `sinal`, `milhar`, `centena`, `dezena` and `unidade` inputs. Out-of-range values produce the dash code on all digits, and leading zeros are optionally blanked.

---
 rtl/conversor_bcd.sv | 151 +++++++++++++++
 tb/tb_conversor_bcd.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/conversor_bcd.sv
// conversor_bcd: signed 32-bit binary to four-digit BCD converter for the
// seven-segment display stage. Magnitude is converted by double-dabble over
// 14 shift cycles; values beyond 9999 show dashes, leading zeros optionally blank.
//
// Handshake: `inicio` is a request sampled only while idle (`ocupado`=0);
// requests seen while busy are dropped, not queued. `pronto` is a one-cycle
// pulse in the same cycle the digit outputs take their new values; the digit
// outputs and `sinal` hold steady at every other time.
module conversor_bcd #(
    parameter bit SUPRIME_ZEROS = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] entrada,
    input  logic        inicio,
    output logic        ocupado,
    output logic        pronto,
    output logic        sinal,
    output logic [3:0]  milhar,
    output logic [3:0]  centena,
    output logic [3:0]  dezena,
    output logic [3:0]  unidade,
    output logic [1:0]  estado
);

    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        CONVERTE = 2'd1,
        FORMATA  = 2'd2
    } estado_t;

    localparam logic [3:0] BRANCO    = 4'hA;
    localparam logic [3:0] TRACO     = 4'hF;
    localparam logic [3:0] DIGITO_RST = SUPRIME_ZEROS ? BRANCO : 4'h0;

    estado_t     estado_q;
    estado_t     estado_d;
    logic [3:0]  contador;
    logic [13:0] bin_q;
    logic [15:0] bcd_q;
    logic        sinal_int;
    logic        estouro;

    logic [31:0] mag;
    logic [15:0] bcd_adj;
    logic [29:0] deslocado;
    logic [3:0]  fmt_milhar;
    logic [3:0]  fmt_centena;
    logic [3:0]  fmt_dezena;
    logic [3:0]  fmt_unidade;

    assign estado = estado_q;

    // Magnitude of the incoming value; -2^31 maps to 2^31 as unsigned.
    always_comb begin
        mag = entrada[31] ? (~entrada + 32'd1) : entrada;
    end

    // Double-dabble step: add 3 to every nibble >= 5, then shift {bcd, bin} left.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 4; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
        deslocado = {bcd_adj, bin_q} << 1;
    end

    // Display formatting: dashes on overflow, otherwise digits with optional
    // leading-zero blanking (units digit always shown).
    always_comb begin
        fmt_milhar  = bcd_q[15:12];
        fmt_centena = bcd_q[11:8];
        fmt_dezena  = bcd_q[7:4];
        fmt_unidade = bcd_q[3:0];
        if (estouro) begin
            fmt_milhar  = TRACO;
            fmt_centena = TRACO;
            fmt_dezena  = TRACO;
            fmt_unidade = TRACO;
        end else if (SUPRIME_ZEROS) begin
            if (bcd_q[15:12] == 4'd0) fmt_milhar  = BRANCO;
            if (bcd_q[15:8]  == 8'd0) fmt_centena = BRANCO;
            if (bcd_q[15:4]  == 12'd0) fmt_dezena = BRANCO;
        end
    end

    // Next-state logic.
    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            OCIOSO:   if (inicio) estado_d = CONVERTE;
            CONVERTE: if (contador == 4'd13) estado_d = FORMATA;
            FORMATA:  estado_d = OCIOSO;
            default:  estado_d = OCIOSO;
        endcase
    end

    // State register; reset aborts any conversion in progress.
    always_ff @(posedge clock) begin
        if (reset) estado_q <= OCIOSO;
        else       estado_q <= estado_d;
    end

    // Datapath: capture on acceptance, shift while converting, publish on format.
    always_ff @(posedge clock) begin
        if (reset) begin
            ocupado   <= 1'b0;
            pronto    <= 1'b0;
            sinal     <= 1'b0;
            milhar    <= DIGITO_RST;
            centena   <= DIGITO_RST;
            dezena    <= DIGITO_RST;
            unidade   <= 4'h0;
            contador  <= 4'd0;
            bin_q     <= 14'd0;
            bcd_q     <= 16'd0;
            sinal_int <= 1'b0;
            estouro   <= 1'b0;
        end else begin
            pronto  <= 1'b0;
            ocupado <= (estado_d != OCIOSO);
            case (estado_q)
                OCIOSO: begin
                    if (inicio) begin
                        sinal_int <= entrada[31];
                        estouro   <= (mag > 32'd9999);
                        bin_q     <= mag[13:0];
                        bcd_q     <= 16'd0;
                        contador  <= 4'd0;
                    end
                end
                CONVERTE: begin
                    bcd_q    <= deslocado[29:14];
                    bin_q    <= deslocado[13:0];
                    contador <= contador + 4'd1;
                end
                FORMATA: begin
                    pronto  <= 1'b1;
                    sinal   <= sinal_int;
                    milhar  <= fmt_milhar;
                    centena <= fmt_centena;
                    dezena  <= fmt_dezena;
                    unidade <= fmt_unidade;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_conversor_bcd.sv
// tb_conversor_bcd: table-driven and randomized checks of conversor_bcd,
// with a second instance built without leading-zero blanking.
module tb_conversor_bcd;

    logic        clock;
    logic        reset;
    logic [31:0] entrada;
    logic        inicio;

    logic        ocupado, pronto, sinal;
    logic [3:0]  milhar, centena, dezena, unidade;
    logic [1:0]  estado;
    logic        ocupado_nz, pronto_nz, sinal_nz;
    logic [3:0]  milhar_nz, centena_nz, dezena_nz, unidade_nz;
    logic [1:0]  estado_nz;

    logic [16:0] out_main;
    logic [16:0] out_nz;
    assign out_main = {sinal, milhar, centena, dezena, unidade};
    assign out_nz   = {sinal_nz, milhar_nz, centena_nz, dezena_nz, unidade_nz};

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [16:0] RST_MAIN = {1'b0, 16'hAAA0};
    localparam logic [16:0] RST_NZ   = 17'h0;

    logic [16:0] prev_main;
    logic [16:0] prev_nz;

    typedef struct {
        logic [31:0] v;
        logic [16:0] exp;
    } vec_t;
    vec_t tab[12];

    conversor_bcd u_dut (
        .clock(clock), .reset(reset), .entrada(entrada), .inicio(inicio),
        .ocupado(ocupado), .pronto(pronto), .sinal(sinal),
        .milhar(milhar), .centena(centena), .dezena(dezena), .unidade(unidade),
        .estado(estado)
    );

    conversor_bcd #(.SUPRIME_ZEROS(1'b0)) u_dut_nz (
        .clock(clock), .reset(reset), .entrada(entrada), .inicio(inicio),
        .ocupado(ocupado_nz), .pronto(pronto_nz), .sinal(sinal_nz),
        .milhar(milhar_nz), .centena(centena_nz), .dezena(dezena_nz), .unidade(unidade_nz),
        .estado(estado_nz)
    );

    // Clock and reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: decimal digits by plain division of the magnitude.
    function automatic logic [16:0] model(input logic [31:0] v, input bit supr);
        longint m;
        logic [3:0] d3, d2, d1, d0;
        m = v[31] ? -longint'($signed(v)) : longint'(v);
        if (m > 9999) return {v[31], 16'hFFFF};
        d3 = 4'(m / 1000);
        d2 = 4'((m / 100) % 10);
        d1 = 4'((m / 10) % 10);
        d0 = 4'(m % 10);
        if (supr) begin
            if (m < 1000) d3 = 4'hA;
            if (m < 100)  d2 = 4'hA;
            if (m < 10)   d1 = 4'hA;
        end
        return {v[31], d3, d2, d1, d0};
    endfunction

    // Driver: one full conversion, checked every cycle from E0 to E16.
    // poke_at = k drives inicio=1/entrada=77 into edge E(k+1); noise drives
    // random requests while busy.
    task automatic run_conv(input logic [31:0] v, input logic [16:0] exp_main,
                            input int poke_at, input bit noise, input string tag);
        logic [16:0] exp_nz;
        exp_nz = model(v, 1'b0);
        @(negedge clock);
        entrada = v;
        inicio  = 1'b1;
        @(posedge clock);
        for (int k = 0; k <= 16; k++) begin
            if (k > 0) @(posedge clock);
            #1;
            if (k < 15)
                check({tag, "_busy"}, {28'd0, ocupado, pronto, out_main, out_nz},
                      {28'd0, 1'b1, 1'b0, prev_main, prev_nz});
            else if (k == 15)
                check({tag, "_done"}, {28'd0, ocupado, pronto, out_main, out_nz},
                      {28'd0, 1'b0, 1'b1, exp_main, exp_nz});
            else
                check({tag, "_after"}, {62'd0, ocupado, pronto}, 64'd0);
            if (k == poke_at) begin
                inicio  = 1'b1;
                entrada = 32'd77;
            end else if (noise && k < 14) begin
                inicio  = 1'($urandom_range(0, 1));
                entrada = $urandom;
            end else begin
                inicio = 1'b0;
            end
        end
        prev_main = exp_main;
        prev_nz   = exp_nz;
    endtask

    initial begin
        logic [31:0] v;
        logic [40:0] pat_act, pat_exp;
        logic [19:0] quiet;

        tab[0]  = '{32'd1234,       {1'b0, 16'h1234}};
        tab[1]  = '{32'hFFFFFD3F,   {1'b1, 16'hA705}};
        tab[2]  = '{32'd0,          {1'b0, 16'hAAA0}};
        tab[3]  = '{32'd9999,       {1'b0, 16'h9999}};
        tab[4]  = '{32'hFFFFD8F1,   {1'b1, 16'h9999}};
        tab[5]  = '{32'd10000,      {1'b0, 16'hFFFF}};
        tab[6]  = '{32'h80000000,   {1'b1, 16'hFFFF}};
        tab[7]  = '{32'h7FFFFFFF,   {1'b0, 16'hFFFF}};
        tab[8]  = '{32'd100,        {1'b0, 16'hA100}};
        tab[9]  = '{32'd1005,       {1'b0, 16'h1005}};
        tab[10] = '{32'hFFFFFFFF,   {1'b1, 16'hAAA1}};
        tab[11] = '{32'd10,         {1'b0, 16'hAA10}};

        // Reset for two cycles with a start request pending: reset wins.
        reset   = 1'b1;
        inicio  = 1'b1;
        entrada = 32'd1234;
        repeat (2) @(posedge clock);
        #1;
        reset  = 1'b0;
        inicio = 1'b0;
        check("reset_main", {45'd0, ocupado, pronto, out_main}, {45'd0, 2'b00, RST_MAIN});
        check("reset_nz",   {45'd0, ocupado_nz, pronto_nz, out_nz}, {45'd0, 2'b00, RST_NZ});
        prev_main = RST_MAIN;
        prev_nz   = RST_NZ;

        // Table-driven vectors, including the range boundaries.
        for (int i = 0; i < 12; i++)
            run_conv(tab[i].v, tab[i].exp, -1, 1'b0, $sformatf("vec%0d", i));

        // Second request while busy is dropped: single result for 42.
        run_conv(32'd42, {1'b0, 16'hAA42}, 4, 1'b0, "ignore_busy");

        // Randomized values with random requests while busy.
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0: v = $urandom_range(0, 9999);
                1: v = -$urandom_range(0, 9999);
                2: begin
                    v = $urandom_range(9990, 10010);
                    if ($urandom_range(0, 1) == 1) v = -v;
                end
                default: v = $urandom;
            endcase
            run_conv(v, model(v, 1'b1), -1, 1'b1, $sformatf("rand%0d", i));
        end

        // inicio held high: pronto every 16 cycles.
        @(negedge clock);
        entrada = 32'd321;
        inicio  = 1'b1;
        @(posedge clock);
        pat_act = '0;
        pat_exp = '0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clock);
            #1;
            pat_act[k] = pronto;
            pat_exp[k] = (k == 15 || k == 31);
            if (k == 15)
                check("held_digits", {47'd0, out_main}, {47'd0, model(32'd321, 1'b1)});
            if (k == 31) inicio = 1'b0;
        end
        check("held_pronto_pattern", {23'd0, pat_act}, {23'd0, pat_exp});
        prev_main = model(32'd321, 1'b1);
        prev_nz   = model(32'd321, 1'b0);

        // Reset at E7 of a conversion aborts it with no pronto.
        @(negedge clock);
        entrada = 32'd8888;
        inicio  = 1'b1;
        @(posedge clock);
        #1;
        inicio = 1'b0;
        repeat (6) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        check("midreset_main", {45'd0, ocupado, pronto, out_main}, {45'd0, 2'b00, RST_MAIN});
        check("midreset_nz",   {45'd0, ocupado_nz, pronto_nz, out_nz}, {45'd0, 2'b00, RST_NZ});
        prev_main = RST_MAIN;
        prev_nz   = RST_NZ;
        quiet = '0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clock);
            #1;
            quiet[k] = pronto | ocupado;
        end
        check("midreset_quiet", {44'd0, quiet}, 64'd0);
        run_conv(32'd8888, {1'b0, 16'h8888}, -1, 1'b0, "after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
